// File: rtl/disp_capture_wr.sv
// disp_capture_wr: writes a sampled RGB pixel stream into VRAM as 16-beat AXI4 write bursts
// Ports: ACLK/ARESETN clock and async active-low reset; PIX_EN + VGA_R/G/B/HS/VS/DE pixel input;
//   CAPADDR/CAPON/CLRDONE capture control; CAPDONE/FIFO_OVER/BRESP_ERR sticky status;
//   M_AXI_AW*/W*/B* AXI4 write master, one burst outstanding at a time.
module disp_capture_wr #(
  parameter int H_PIX      = 640,
  parameter int V_PIX      = 480,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        PIX_EN,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_DE,
  input  logic [31:0] CAPADDR,
  input  logic        CAPON,
  input  logic        CLRDONE,
  output logic        CAPDONE,
  output logic        FIFO_OVER,
  output logic        BRESP_ERR,
  output logic [31:0] M_AXI_AWADDR,
  output logic [7:0]  M_AXI_AWLEN,
  output logic [2:0]  M_AXI_AWSIZE,
  output logic [1:0]  M_AXI_AWBURST,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WLAST,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY
);
  localparam int FRM_WORDS = H_PIX * V_PIX;
  localparam int NBURST    = FRM_WORDS / 16;
  localparam int AB        = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t      state_q;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AB:0] wr_q, rd_q, level;
  logic [31:0] base_q, pix_cnt_q, burst_q, awaddr_q;
  logic [3:0]  beat_q;
  logic        vs_q, busy_q, awvalid_q, done_q, over_q, err_q;
  logic        arm, take, push, pop, full, unused_ok;
  assign level = wr_q - rd_q;
  assign full  = level[AB];
  // VS is only meaningful on pixel-enable cycles, so the edge detector samples on those alone
  assign arm  = PIX_EN && vs_q && !VGA_VS && CAPON && !busy_q;
  // pix_cnt_q counts queued words: after a drop, later pixels fill the gap so the
  // frame still ends with exactly FRM_WORDS written (shifted image, flagged by FIFO_OVER)
  assign take = busy_q && PIX_EN && VGA_DE && (pix_cnt_q < 32'(FRM_WORDS));
  assign push = take && !full;
  assign pop  = M_AXI_WVALID && M_AXI_WREADY;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWLEN   = 8'd15;
  assign M_AXI_AWSIZE  = 3'd2;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = mem[rd_q[AB-1:0]];
  assign M_AXI_WSTRB   = 4'hF;
  // the burst only starts with 16 words queued, so WVALID never drops before beat 15
  assign M_AXI_WVALID  = (state_q == DATA) && (level != '0);
  assign M_AXI_WLAST   = (state_q == DATA) && (beat_q == 4'd15);
  assign M_AXI_BREADY  = state_q == RESP;
  assign CAPDONE       = done_q;
  assign FIFO_OVER     = over_q;
  assign BRESP_ERR     = err_q;
  assign unused_ok     = VGA_HS ^ (^CAPADDR[5:0]);
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_q[AB-1:0]] <= {8'h00, VGA_R, VGA_G, VGA_B};
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      wr_q      <= '0;
      rd_q      <= '0;
      base_q    <= '0;
      pix_cnt_q <= '0;
      burst_q   <= '0;
      awaddr_q  <= '0;
      beat_q    <= '0;
      vs_q      <= 1'b0;
      busy_q    <= 1'b0;
      awvalid_q <= 1'b0;
      done_q    <= 1'b0;
      over_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (PIX_EN) vs_q <= VGA_VS;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      // clears come first so a same-cycle set event below wins
      if (CLRDONE) begin
        done_q <= 1'b0;
        over_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (take && full) over_q <= 1'b1;
      if (arm) begin
        base_q    <= {CAPADDR[31:6], 6'b0};
        pix_cnt_q <= '0;
        burst_q   <= '0;
        busy_q    <= 1'b1;
      end else if (push) pix_cnt_q <= pix_cnt_q + 32'd1;
      case (state_q)
        IDLE: if (level >= (AB+1)'(16)) begin
          state_q   <= ADDR;
          awvalid_q <= 1'b1;
          awaddr_q  <= base_q + (burst_q << 6);
        end
        ADDR: if (M_AXI_AWREADY) begin
          state_q   <= DATA;
          awvalid_q <= 1'b0;
          beat_q    <= '0;
        end
        DATA: if (pop) begin
          beat_q <= beat_q + 1'b1;
          if (beat_q == 4'd15) state_q <= RESP;
        end
        RESP: if (M_AXI_BVALID) begin
          state_q <= IDLE;
          burst_q <= burst_q + 32'd1;
          if (M_AXI_BRESP != 2'b00) err_q <= 1'b1;
          if (burst_q + 32'd1 == 32'(NBURST)) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
